// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I pipeline control blocks.
//   hz_state_e        - hazard controller FSM states
//   STALL_TIMEOUT_DEF - default number of consecutive stall cycles before the
//                       watchdog declares a hang
package riscv_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    localparam int STALL_TIMEOUT_DEF = 200;

endpackage : riscv_pkg

// File: rtl/hazard_ctrl_scoreboard.sv
// hazard_ctrl_scoreboard: per-register "long-latency write in flight" bits.
//   clk_i, rstn_i          - clock, synchronous active-low reset
//   set_en_i/set_addr_i    - mark a register as pending (issue of load/multicycle op)
//   clr_en_i/clr_addr_i    - retire a pending register (long-latency writeback)
//   rs1/rs2/rd_addr_i      - decode lookup indices
//   rs1/rs2/rd_hit_o       - pending bit of each looked-up register
//   pending_o              - full scoreboard vector
// Bit 0 is never set, so lookups of x0 never hit without extra masking.
module hazard_ctrl_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            set_en_i,
    input  logic [4:0]      set_addr_i,
    input  logic            clr_en_i,
    input  logic [4:0]      clr_addr_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      rd_addr_i,
    output logic            rs1_hit_o,
    output logic            rs2_hit_o,
    output logic            rd_hit_o,
    output logic [NREG-1:0] pending_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;

    // One-hot mask for a register index; x0 never produces a bit.
    function automatic logic [NREG-1:0] idx_mask(input logic en, input logic [4:0] addr);
        logic [NREG-1:0] m;
        m = {NREG{1'b0}};
        if (en && (addr != 5'd0)) begin
            m[addr] = 1'b1;
        end else begin
            m = {NREG{1'b0}};
        end
        return m;
    endfunction

    // Next scoreboard value: clear first, then set, so a same-index set wins.
    always_comb begin
        set_mask_s = idx_mask(set_en_i, set_addr_i);
        clr_mask_s = idx_mask(clr_en_i, clr_addr_i);
        pend_d     = ((pend_q & ~clr_mask_s) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
    end

    // Scoreboard register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_q <= {NREG{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rs1_hit_o = pend_q[rs1_addr_i];
    assign rs2_hit_o = pend_q[rs2_addr_i];
    assign rd_hit_o  = pend_q[rd_addr_i];
    assign pending_o = pend_q;

endmodule : hazard_ctrl_scoreboard

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW/WAW stall and EX-redirect flush sequencing for the 5-stage core.
//   clk_i, rstn_i                       - clock, synchronous active-low reset
//   valid_D_i, rs1/rs2/rsd_addr_D_i,
//   rs1/rs2_used_D_i, rd_wrt_ena_D_i,
//   long_lat_D_i                        - decode-stage instruction description
//   wb_valid_i, wb_long_i, wb_addr_i    - writeback retiring a long-latency result
//   redirect_E_i                        - taken branch/jump resolved in EX
//   stall_pc_o, stall_fd_o              - hold PC and F/D register
//   flush_fd_o, flush_de_o              - clear F/D, bubble into D/E
//   pending_o                           - scoreboard bits
//   timeout_o                           - sticky stall-watchdog error
// Stall/flush outputs are combinational on the inputs plus registered state,
// and are forced low while reset is asserted.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int NREG          = 32,
    parameter int TO_W          = 8,
    parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_D_i,
    input  logic [4:0]      rs1_addr_D_i,
    input  logic [4:0]      rs2_addr_D_i,
    input  logic            rs1_used_D_i,
    input  logic            rs2_used_D_i,
    input  logic [4:0]      rsd_addr_D_i,
    input  logic            rd_wrt_ena_D_i,
    input  logic            long_lat_D_i,
    input  logic            wb_valid_i,
    input  logic            wb_long_i,
    input  logic [4:0]      wb_addr_i,
    input  logic            redirect_E_i,
    output logic            stall_pc_o,
    output logic            stall_fd_o,
    output logic            flush_fd_o,
    output logic            flush_de_o,
    output logic [NREG-1:0] pending_o,
    output logic            timeout_o
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(STALL_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic rs1_hit_s, rs2_hit_s, rd_hit_s;
    logic hazard_s, issue_s, sb_set_s, sb_clr_s;
    logic stall_s, flush_s;

    hazard_ctrl_scoreboard #(.NREG(NREG)) u_sb (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .set_en_i   (sb_set_s),
        .set_addr_i (rsd_addr_D_i),
        .clr_en_i   (sb_clr_s),
        .clr_addr_i (wb_addr_i),
        .rs1_addr_i (rs1_addr_D_i),
        .rs2_addr_i (rs2_addr_D_i),
        .rd_addr_i  (rsd_addr_D_i),
        .rs1_hit_o  (rs1_hit_s),
        .rs2_hit_o  (rs2_hit_s),
        .rd_hit_o   (rd_hit_s),
        .pending_o  (pending_o)
    );

    // Hazard detection and issue qualification. A writeback clearing the
    // register this cycle does not unstall: the scoreboard still shows it pending.
    always_comb begin
        hazard_s = valid_D_i & ((rs1_used_D_i   & rs1_hit_s) |
                                (rs2_used_D_i   & rs2_hit_s) |
                                (rd_wrt_ena_D_i & rd_hit_s));
        issue_s  = valid_D_i & ~hazard_s & ~redirect_E_i & (state_q != HZ_FLUSH);
        sb_set_s = issue_s & rd_wrt_ena_D_i & long_lat_D_i;
        sb_clr_s = wb_valid_i & wb_long_i;
    end

    // FSM next state and stall/flush decode; redirect outranks hazard, and the
    // cycle after a redirect flushes the wrong-path fetch already in flight.
    always_comb begin
        state_d = state_q;
        stall_s = 1'b0;
        flush_s = 1'b0;
        if (!rstn_i) begin
            state_d = HZ_RUN;
        end else if (redirect_E_i) begin
            flush_s = 1'b1;
            state_d = HZ_FLUSH;
        end else begin
            case (state_q)
                HZ_FLUSH: begin
                    flush_s = 1'b1;
                    state_d = hazard_s ? HZ_STALL : HZ_RUN;
                end
                HZ_RUN, HZ_STALL: begin
                    stall_s = hazard_s;
                    state_d = hazard_s ? HZ_STALL : HZ_RUN;
                end
                default: begin
                    state_d = HZ_RUN;
                end
            endcase
        end
    end

    // Watchdog: count consecutive stall cycles (saturating), latch error at the limit.
    always_comb begin
        wd_d      = {TO_W{1'b0}};
        timeout_d = timeout_q;
        if (stall_s) begin
            wd_d = (wd_q == TO_MAX) ? TO_MAX : (wd_q + {{(TO_W-1){1'b0}}, 1'b1});
        end else begin
            wd_d = {TO_W{1'b0}};
        end
        if (stall_s && (wd_d >= TO_LIM)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State, watchdog and error registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= HZ_RUN;
            wd_q      <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_pc_o = stall_s;
    assign stall_fd_o = stall_s;
    assign flush_fd_o = flush_s;
    assign flush_de_o = flush_s | stall_s;
    assign timeout_o  = timeout_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid, u1, u2, we, lng, wbv, wbl, redir;
    logic [4:0]  rs1, rs2, rd, wba;
    logic        stall_pc, stall_fd, flush_fd, flush_de, timeout;
    logic [31:0] pending;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .valid_D_i      (valid),
        .rs1_addr_D_i   (rs1),
        .rs2_addr_D_i   (rs2),
        .rs1_used_D_i   (u1),
        .rs2_used_D_i   (u2),
        .rsd_addr_D_i   (rd),
        .rd_wrt_ena_D_i (we),
        .long_lat_D_i   (lng),
        .wb_valid_i     (wbv),
        .wb_long_i      (wbl),
        .wb_addr_i      (wba),
        .redirect_E_i   (redir),
        .stall_pc_o     (stall_pc),
        .stall_fd_o     (stall_fd),
        .flush_fd_o     (flush_fd),
        .flush_de_o     (flush_de),
        .pending_o      (pending),
        .timeout_o      (timeout)
    );

    typedef struct {
        logic [4:0]  ctl;   // {stall_pc, stall_fd, flush_fd, flush_de, timeout}
        logic [31:0] pend;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    string       phase = "init";

    // reference model state
    logic [31:0] m_pend;
    bit          m_flush;
    int          m_cnt;
    bit          m_to;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    task automatic drive_d(input logic v, input logic [4:0] a1, input logic e1,
                           input logic [4:0] a2, input logic e2,
                           input logic [4:0] d, input logic w, input logic l);
        valid = v; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; rd = d; we = w; lng = l;
    endtask

    task automatic drive_wb(input logic v, input logic l, input logic [4:0] a);
        wbv = v; wbl = l; wba = a;
    endtask

    task automatic idle();
        drive_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive_wb(1'b0, 1'b0, 5'd0);
        redir = 1'b0;
        rstn  = 1'b1;
    endtask

    // One clock: predict, push, compare the DUT against the popped entry, advance model.
    task automatic step();
        exp_t  e, g;
        bit    hz, stl, fl, iss;
        logic [31:0] np;
        int    nc;
        #1;
        hz = valid && ((u1 && rs1 != 5'd0 && m_pend[rs1]) ||
                       (u2 && rs2 != 5'd0 && m_pend[rs2]) ||
                       (we && rd  != 5'd0 && m_pend[rd]));
        stl = 1'b0; fl = 1'b0;
        if (rstn) begin
            if (redir || m_flush) fl = 1'b1;
            else if (hz)          stl = 1'b1;
        end
        e.ctl  = {stl, stl, fl, fl | stl, m_to};
        e.pend = m_pend;
        exp_q.push_back(e);

        iss = valid && !hz && !redir && !m_flush;
        np  = m_pend;
        if (wbv && wbl && wba != 5'd0) np[wba] = 1'b0;
        if (iss && we && lng && rd != 5'd0) np[rd] = 1'b1;
        nc = stl ? ((m_cnt >= 255) ? 255 : m_cnt + 1) : 0;

        g = exp_q.pop_front();
        check_val("ctl",  {59'd0, stall_pc, stall_fd, flush_fd, flush_de, timeout}, {59'd0, g.ctl});
        check_val("pend", {32'd0, pending}, {32'd0, g.pend});

        @(posedge clk);
        if (!rstn) begin
            m_pend = 32'd0; m_flush = 1'b0; m_cnt = 0; m_to = 1'b0;
        end else begin
            m_to    = m_to || (stl && nc >= 200);
            m_pend  = np;
            m_flush = redir;
            m_cnt   = nc;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_pend = 32'd0; m_flush = 1'b0; m_cnt = 0; m_to = 1'b0;

        // reset held: all outputs low
        phase = "reset";
        rstn = 1'b0; step(); step();

        // load-use: LW x5, then ADD x6,x5,x1 stalls until WB retires x5
        phase = "loaduse";
        idle(); drive_d(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); step();
        drive_d(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        repeat (3) step();
        drive_wb(1'b1, 1'b1, 5'd5); step();
        drive_wb(1'b0, 1'b0, 5'd0); step();
        idle(); step();

        // x0 immunity
        phase = "x0";
        drive_d(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); step();
        drive_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0); step(); step();
        idle(); step();

        // WAW on x9
        phase = "waw";
        drive_d(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1); step();
        repeat (2) step();
        drive_wb(1'b1, 1'b1, 5'd9); step();
        drive_wb(1'b0, 1'b0, 5'd0); step();
        idle(); step();
        drive_wb(1'b1, 1'b1, 5'd9); step();
        idle(); step();

        // redirect while stalled on x7
        phase = "redirect";
        drive_d(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        drive_d(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); step();
        redir = 1'b1; step();
        idle(); step(); step();
        drive_wb(1'b1, 1'b1, 5'd7); step();
        idle(); step();

        // watchdog on x3
        phase = "watchdog";
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); step();
        drive_d(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        repeat (205) step();
        drive_wb(1'b1, 1'b1, 5'd3); step();
        drive_wb(1'b0, 1'b0, 5'd0); step();
        idle(); repeat (3) step();
        rstn = 1'b0; step();
        idle(); step();

        // reset mid-stall with x5 and x10 pending
        phase = "midreset";
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5,  1'b1, 1'b1); step();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1); step();
        drive_d(1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0); step(); step();
        rstn = 1'b0; step();
        rstn = 1'b1; step();
        idle(); step();

        // random traffic on a small register window
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            drive_d(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive_wb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            redir = ($urandom_range(0, 9) == 0);
            rstn  = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl
